// File: rtl/aes256_inv_key_schedule_if.sv
// aes256_inv_key_schedule_if: key load and round-key stream handshake bundle
interface aes256_inv_key_schedule_if;
    logic [0:255] key_i;
    logic         key_v_i;
    logic         key_ready_o;
    logic [0:127] rk_o;
    logic [3:0]   rk_idx_o;
    logic         rk_v_o;
    logic         rk_ready_i;
    logic         rk_last_o;
    modport slave (
        input  key_i, key_v_i, rk_ready_i,
        output key_ready_o, rk_o, rk_idx_o, rk_v_o, rk_last_o
    );
    modport master (
        output key_i, key_v_i, rk_ready_i,
        input  key_ready_o, rk_o, rk_idx_o, rk_v_o, rk_last_o
    );
endinterface

// File: rtl/aes256_inv_key_schedule.sv
// aes256_inv_key_schedule: runs AES-256 key expansion backwards, emitting rk14 down to rk0
module aes256_inv_key_schedule (
    input logic clk_i,
    input logic reset_i,
    aes256_inv_key_schedule_if.slave bus
);
    typedef enum logic {IDLE, EMIT} state_t;
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    state_t      state;
    logic [31:0] w [8];
    logic [3:0]  round;
    logic [31:0] x;
    logic [31:0] f0;
    logic [7:0]  rcon;
    logic        accept;
    // f_0 of the backward step: even rounds undo RotWord+SubWord+Rcon, odd rounds SubWord only
    always_comb begin
        x      = round[0] ? w[3] : {w[3][23:0], w[3][31:24]};
        rcon   = 8'h01 << (round[3:1] - 3'd1);
        f0     = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]} ^ (round[0] ? 32'h0 : {rcon, 24'h0});
        accept = bus.rk_v_o && bus.rk_ready_i;
    end
    // load/emit state machine; W slides one round key down per accepted output
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= IDLE;
            w               <= '{default: '0};
            round           <= '0;
            bus.key_ready_o <= 1'b1;
            bus.rk_v_o      <= 1'b0;
            bus.rk_o        <= '0;
            bus.rk_idx_o    <= '0;
            bus.rk_last_o   <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.key_v_i && bus.key_ready_o) begin
                for (int i = 0; i < 8; i++) w[i] <= bus.key_i[32*i +: 32];
                round           <= 4'd14;
                state           <= EMIT;
                bus.key_ready_o <= 1'b0;
                bus.rk_v_o      <= 1'b1;
                bus.rk_o        <= bus.key_i[128:255];
                bus.rk_idx_o    <= 4'd14;
                bus.rk_last_o   <= 1'b0;
            end
        end else if (accept) begin
            if (round == 4'd0) begin
                state           <= IDLE;
                bus.rk_v_o      <= 1'b0;
                bus.key_ready_o <= 1'b1;
                bus.rk_last_o   <= 1'b0;
            end else begin
                w[0] <= w[4] ^ f0;
                for (int i = 1; i < 4; i++) w[i] <= w[4+i] ^ w[3+i];
                for (int i = 0; i < 4; i++) w[4+i] <= w[i];
                round         <= round - 4'd1;
                bus.rk_o      <= {w[0], w[1], w[2], w[3]};
                bus.rk_idx_o  <= round - 4'd1;
                bus.rk_last_o <= (round == 4'd1);
            end
        end
    end
endmodule

// File: tb/tb_aes256_inv_key_schedule.sv
// tb_aes256_inv_key_schedule: random and directed streams checked against a forward-expansion model
module tb_aes256_inv_key_schedule;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [7:0]  sb [256];
    logic [31:0] ew [60];
    logic [31:0] tw [60];
    logic [255:0] k;

    always #5 clk = ~clk;

    aes256_inv_key_schedule_if bus ();
    aes256_inv_key_schedule dut (.clk_i(clk), .reset_i(reset_i), .bus(bus.slave));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= a;
            a = xt(a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            sb[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    function automatic void expand(input logic [255:0] key, output logic [31:0] w [60]);
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) t = subw(t);
            w[i] = w[i-8] ^ t;
        end
    endfunction

    function automatic logic [127:0] rk_of(input int r);
        return {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
    endfunction

    function automatic logic [255:0] load_of(input logic [31:0] w [60]);
        return {w[52], w[53], w[54], w[55], w[56], w[57], w[58], w[59]};
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start(input logic [255:0] ld);
        int n = 0;
        while (!bus.key_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("key_ready_idle", 256'(bus.key_ready_o), 256'd1);
        bus.key_i   = ld;
        bus.key_v_i = 1'b1;
        @(negedge clk);
        bus.key_v_i = 1'b0;
    endtask

    task automatic drain(input int pct, input bit pulse, input bit b2b, input logic [255:0] nxt, input int abort_at);
        int idx = 14;
        int cyc = 0;
        bit rdy;
        bit done = 1'b0;
        while (!done && cyc < 2000) begin
            chk("rk_v", 256'(bus.rk_v_o), 256'd1);
            chk("rk_idx", 256'(bus.rk_idx_o), 256'(idx));
            chk("rk", 256'(bus.rk_o), 256'(rk_of(idx)));
            chk("rk_last", 256'(bus.rk_last_o), 256'(idx == 0));
            chk("key_ready_emit", 256'(bus.key_ready_o), 256'd0);
            if (idx == abort_at) begin
                reset_i = 1'b1;
                bus.rk_ready_i = 1'b0;
                @(negedge clk);
                reset_i = 1'b0;
                chk("abort_rk_v", 256'(bus.rk_v_o), 256'd0);
                chk("abort_rk", 256'(bus.rk_o), 256'd0);
                chk("abort_key_ready", 256'(bus.key_ready_o), 256'd1);
                chk("abort_rk_last", 256'(bus.rk_last_o), 256'd0);
                return;
            end
            rdy = $urandom_range(0, 99) < pct;
            bus.rk_ready_i = rdy;
            if (b2b && rdy && idx == 0) begin
                bus.key_i   = nxt;
                bus.key_v_i = 1'b1;
            end else begin
                bus.key_i   = rnd256();
                bus.key_v_i = pulse && ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            cyc++;
            if (rdy) begin
                if (idx == 0) done = 1'b1;
                else idx--;
            end
        end
        chk("stream_done", 256'(done), 256'd1);
        bus.rk_ready_i = 1'b0;
        if (!b2b) bus.key_v_i = 1'b0;
        chk("rk_v_after_last", 256'(bus.rk_v_o), 256'd0);
        chk("key_ready_after_last", 256'(bus.key_ready_o), 256'd1);
        chk("rk_last_after_last", 256'(bus.rk_last_o), 256'd0);
        if (b2b) begin
            @(negedge clk);
            bus.key_v_i = 1'b0;
        end
    endtask

    initial begin
        build_sbox();
        bus.key_i      = '0;
        bus.key_v_i    = 1'b0;
        bus.rk_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        chk("rst_key_ready", 256'(bus.key_ready_o), 256'd1);
        chk("rst_rk_v", 256'(bus.rk_v_o), 256'd0);
        chk("rst_rk", 256'(bus.rk_o), 256'd0);
        chk("rst_rk_idx", 256'(bus.rk_idx_o), 256'd0);
        chk("rst_rk_last", 256'(bus.rk_last_o), 256'd0);

        k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        expand(k, ew);
        start(load_of(ew));
        chk("fips_rk14", 256'(bus.rk_o), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));
        chk("fips_model_rk1", 256'(rk_of(1)), 256'(128'h101112131415161718191a1b1c1d1e1f));
        drain(100, 1'b0, 1'b0, '0, -1);

        expand(rnd256(), ew);
        start(load_of(ew));
        drain(50, 1'b1, 1'b0, '0, -1);

        expand({256{1'b1}}, tw);
        expand(rnd256(), ew);
        start(load_of(ew));
        drain(60, 1'b1, 1'b1, load_of(tw), -1);
        ew = tw;
        drain(100, 1'b0, 1'b0, '0, -1);

        expand(rnd256(), ew);
        start(load_of(ew));
        drain(100, 1'b0, 1'b0, '0, 7);
        start(load_of(ew));
        drain(50, 1'b0, 1'b0, '0, -1);

        for (int n = 0; n < 200; n++) begin
            expand(rnd256(), ew);
            start(load_of(ew));
            drain((n % 2 == 1) ? 50 : 100, n % 3 == 0, 1'b0, '0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
